// File: rtl/l2_pkg.sv
// Shared encodings for the L2 snoop responder: MESI states, bus snoop ops, result codes, FSM states.
// Also holds the MESI downgrade and result-code helpers used by the responder.
package l2_pkg;

    localparam int ADDR_W_DEF   = 32;
    localparam int OFFSET_W_DEF = 6;
    localparam int INDEX_W_DEF  = 14;
    localparam int TAG_W_DEF    = 12;
    localparam int WAY_W_DEF    = 3;

    typedef enum logic [1:0] {
        MESI_I = 2'd0,
        MESI_S = 2'd1,
        MESI_E = 2'd2,
        MESI_M = 2'd3
    } mesi_e;

    typedef enum logic [2:0] {
        OP_READ  = 3'd1,
        OP_WRITE = 3'd2,
        OP_INVAL = 3'd3,
        OP_RWIM  = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        RES_HIT   = 2'd0,
        RES_HITM  = 2'd1,
        RES_NOHIT = 2'd2
    } res_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_EVAL   = 3'd2,
        ST_WB     = 3'd3,
        ST_UPDATE = 3'd4
    } state_e;

    function automatic logic op_legal(input logic [2:0] op);
        return (op == OP_READ) || (op == OP_WRITE) || (op == OP_INVAL) || (op == OP_RWIM);
    endfunction

    // Illegal ops always answer NOHIT, whatever the tag array says.
    function automatic logic [1:0] snoop_code(input logic [2:0] op, input logic hit,
                                              input logic [1:0] mesi);
        logic [1:0] code;
        code = RES_NOHIT;
        if (op_legal(op) && hit) begin
            if (mesi == MESI_M)
                code = RES_HITM;
            else if (mesi == MESI_E || mesi == MESI_S)
                code = RES_HIT;
        end
        return code;
    endfunction

    // State left behind in this cache after another agent's snoop.
    function automatic logic [1:0] next_mesi(input logic [2:0] op, input logic [1:0] cur);
        logic [1:0] nxt;
        nxt = cur;
        case (op)
            OP_READ:  if (cur == MESI_M || cur == MESI_E) nxt = MESI_S;
            OP_RWIM,
            OP_INVAL: nxt = MESI_I;
            default:  nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/l2_snoop_stats.sv
// Three saturating snoop-result counters (HIT / HITM / NOHIT), bumped on each result strobe.
// Only instantiated when SNOOP_STATS_EN is defined.
module l2_snoop_stats
    import l2_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             res_valid,
    input  logic [1:0]       res_code,
    output logic [CNT_W-1:0] stat_hit,
    output logic [CNT_W-1:0] stat_hitm,
    output logic [CNT_W-1:0] stat_nohit
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_hit   <= '0;
            stat_hitm  <= '0;
            stat_nohit <= '0;
        end else if (res_valid) begin
            case (res_code)
                RES_HIT:   if (stat_hit   != CNT_MAX) stat_hit   <= stat_hit + 1'b1;
                RES_HITM:  if (stat_hitm  != CNT_MAX) stat_hitm  <= stat_hitm + 1'b1;
                RES_NOHIT: if (stat_nohit != CNT_MAX) stat_nohit <= stat_nohit + 1'b1;
                default:   ;
            endcase
        end
    end

endmodule

// File: rtl/l2_snoop_responder.sv
// L2 snoop responder: IDLE -> LOOKUP -> EVAL -> [WB] -> UPDATE -> IDLE, all outputs registered.
// Define SNOOP_STATS_EN to add the stat_hit / stat_hitm / stat_nohit counter outputs.
module l2_snoop_responder
    import l2_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int OFFSET_W = OFFSET_W_DEF,
    parameter int INDEX_W  = INDEX_W_DEF,
    parameter int TAG_W    = TAG_W_DEF,
    parameter int WAY_W    = WAY_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               snp_valid,
    output logic               snp_ready,
    input  logic [2:0]         snp_op,
    input  logic [ADDR_W-1:0]  snp_addr,
    output logic               lkp_req,
    output logic [INDEX_W-1:0] lkp_index,
    output logic [TAG_W-1:0]   lkp_tag,
    input  logic               lkp_hit,
    input  logic [WAY_W-1:0]   lkp_way,
    input  logic [1:0]         lkp_mesi,
    output logic               res_valid,
    output logic [1:0]         res_code,
    output logic               wb_req,
    output logic [ADDR_W-1:0]  wb_addr,
    input  logic               wb_ack,
    output logic               upd_en,
    output logic [INDEX_W-1:0] upd_index,
    output logic [WAY_W-1:0]   upd_way,
    output logic [1:0]         upd_mesi,
`ifdef SNOOP_STATS_EN
    output logic [31:0]        stat_hit,
    output logic [31:0]        stat_hitm,
    output logic [31:0]        stat_nohit,
`endif
    output state_e             fsm_state
);

    // Handshake: a snoop transfers on a rising edge where snp_valid && snp_ready;
    // snp_ready is high only in IDLE, so a held snp_valid simply waits for the next IDLE.

    state_e     state;
    logic [2:0] op_q;
    logic       upd_pend;

    logic [1:0] eval_code;
    logic [1:0] eval_mesi;
    logic       eval_upd;
    logic       eval_wb;

    logic       unused_offset;
    assign unused_offset = ^snp_addr[OFFSET_W-1:0];

    always_comb begin
        eval_code = snoop_code(op_q, lkp_hit, lkp_mesi);
        eval_mesi = next_mesi(op_q, lkp_mesi);
        eval_upd  = 1'b0;
        eval_wb   = 1'b0;
        if (op_legal(op_q) && lkp_hit && lkp_mesi != MESI_I && eval_mesi != lkp_mesi)
            eval_upd = 1'b1;
        if (eval_code == RES_HITM && (op_q == OP_READ || op_q == OP_RWIM))
            eval_wb = 1'b1;
    end

    assign fsm_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            upd_pend  <= 1'b0;
            snp_ready <= 1'b1;
            lkp_req   <= 1'b0;
            lkp_index <= '0;
            lkp_tag   <= '0;
            res_valid <= 1'b0;
            res_code  <= '0;
            wb_req    <= 1'b0;
            wb_addr   <= '0;
            upd_en    <= 1'b0;
            upd_index <= '0;
            upd_way   <= '0;
            upd_mesi  <= '0;
        end else begin
            res_valid <= 1'b0;
            upd_en    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (snp_valid) begin
                        op_q      <= snp_op;
                        lkp_index <= snp_addr[OFFSET_W +: INDEX_W];
                        lkp_tag   <= snp_addr[OFFSET_W+INDEX_W +: TAG_W];
                        lkp_req   <= 1'b1;
                        snp_ready <= 1'b0;
                        state     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    lkp_req <= 1'b0;
                    state   <= ST_EVAL;
                end
                ST_EVAL: begin
                    res_valid <= 1'b1;
                    res_code  <= eval_code;
                    upd_pend  <= eval_upd;
                    if (eval_upd) begin
                        upd_index <= lkp_index;
                        upd_way   <= lkp_way;
                        upd_mesi  <= eval_mesi;
                    end
                    if (eval_wb) begin
                        wb_req  <= 1'b1;
                        wb_addr <= {lkp_tag, lkp_index, {OFFSET_W{1'b0}}};
                        state   <= ST_WB;
                    end else begin
                        upd_en <= eval_upd;
                        state  <= ST_UPDATE;
                    end
                end
                ST_WB: begin
                    // The downgrade is committed only after the dirty line has left.
                    if (wb_ack) begin
                        wb_req <= 1'b0;
                        upd_en <= upd_pend;
                        state  <= ST_UPDATE;
                    end
                end
                ST_UPDATE: begin
                    upd_pend  <= 1'b0;
                    snp_ready <= 1'b1;
                    state     <= ST_IDLE;
                end
                default: begin
                    snp_ready <= 1'b1;
                    lkp_req   <= 1'b0;
                    wb_req    <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SNOOP_STATS_EN
    l2_snoop_stats #(.CNT_W(32)) u_stats (
        .clk        (clk),
        .rst_n      (rst_n),
        .res_valid  (res_valid),
        .res_code   (res_code),
        .stat_hit   (stat_hit),
        .stat_hitm  (stat_hitm),
        .stat_nohit (stat_nohit)
    );
`endif

endmodule
